// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - merges pipeline and mul/div results onto one register file write port
// Pipeline writes always win; mul/div results wait in a small FIFO and drain in idle cycles.
module regfile_write_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_en,
   input  logic [4:0]    pipe_num,
   input  logic [31:0]   pipe_data,
   input  logic          md_valid,
   output logic          md_ready,
   input  logic [4:0]    md_num,
   input  logic [31:0]   md_data,
   input  logic [4:0]    chk_num,
   output logic          chk_pending,
   output logic [4:0]    write_num,
   output logic [31:0]   write_data,
   output logic          write_en,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [4:0]    num_q  [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    write_num_q, write_num_d;
   logic [31:0]   write_data_q, write_data_d;
   logic          write_en_q, write_en_d;
   logic          pipe_take;
   logic          enq;
   logic          pop;

   assign md_ready   = (count_q != CW'(DEPTH));
   assign pipe_take  = pipe_en && (pipe_num != 5'd0);
   // r0 offers complete the handshake but are never stored.
   assign enq        = md_valid && md_ready && (md_num != 5'd0);
   assign pop        = !pipe_take && (count_q != '0);
   assign write_num  = write_num_q;
   assign write_data = write_data_q;
   assign write_en   = write_en_q;
   assign count      = count_q;

   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      write_num_d  = write_num_q;
      write_data_d = write_data_q;
      write_en_d   = 1'b0;
      if (pipe_take) begin
         write_num_d  = pipe_num;
         write_data_d = pipe_data;
         write_en_d   = 1'b1;
      end else if (pop) begin
         write_num_d  = num_q[head_q];
         write_data_d = data_q[head_q];
         write_en_d   = 1'b1;
         head_d       = head_q + 1'b1;
      end
      if (enq) begin
         tail_d = tail_q + 1'b1;
      end
      if (enq && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !enq) begin
         count_d = count_q - 1'b1;
      end
   end

   // Only slots in [head, head+count) are live; anything else is stale.
   always_comb begin
      chk_pending = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_q) && (num_q[head_q + AW'(i)] == chk_num)) begin
            chk_pending = 1'b1;
         end
      end
      if (chk_num == 5'd0) begin
         chk_pending = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         write_num_q  <= '0;
         write_data_q <= '0;
         write_en_q   <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         write_num_q  <= write_num_d;
         write_data_q <= write_data_d;
         write_en_q   <= write_en_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (enq) begin
         num_q[tail_q]  <= md_num;
         data_q[tail_q] <= md_data;
      end
   end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - self-checking bench for regfile_write_queue
// Reference model: an ordered queue of pending mul/div writes plus the last register-file write.
module tb_regfile_write_queue;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          pipe_en;
   logic [4:0]    pipe_num;
   logic [31:0]   pipe_data;
   logic          md_valid;
   logic          md_ready;
   logic [4:0]    md_num;
   logic [31:0]   md_data;
   logic [4:0]    chk_num;
   logic          chk_pending;
   logic [4:0]    write_num;
   logic [31:0]   write_data;
   logic          write_en;
   logic [CW-1:0] count;

   regfile_write_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .pipe_en(pipe_en), .pipe_num(pipe_num), .pipe_data(pipe_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_num(md_num), .md_data(md_data),
      .chk_num(chk_num), .chk_pending(chk_pending),
      .write_num(write_num), .write_data(write_data), .write_en(write_en),
      .count(count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [36:0] mq[$];
   logic        m_we;
   logic [4:0]  m_wn;
   logic [31:0] m_wd;
   logic        last_acc;
   logic        last_take;

   task automatic model_reset();
      mq.delete();
      m_we = 1'b0;
      m_wn = 5'd0;
      m_wd = 32'd0;
   endtask

   function automatic logic m_pend(input logic [4:0] n);
      if (n == 5'd0) return 1'b0;
      foreach (mq[i]) if (mq[i][36:32] == n) return 1'b1;
      return 1'b0;
   endfunction

   // Apply the current inputs to the model, then advance one clock.
   task automatic cycle();
      logic [36:0] e;
      logic        rdy;
      rdy       = (mq.size() != DEPTH);
      last_take = pipe_en && (pipe_num != 5'd0);
      last_acc  = md_valid && rdy;
      if (last_take) begin
         m_we = 1'b1; m_wn = pipe_num; m_wd = pipe_data;
      end else if (mq.size() != 0) begin
         e = mq.pop_front();
         m_we = 1'b1; m_wn = e[36:32]; m_wd = e[31:0];
      end else begin
         m_we = 1'b0;
      end
      if (last_acc && md_num != 5'd0) mq.push_back({md_num, md_data});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pipe_en = 1'b0; pipe_num = 5'd0; pipe_data = 32'd0;
      md_valid = 1'b0; md_num = 5'd0; md_data = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      chk_num = 5'd5;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
      n_cmp++; if (write_en !== 1'b0 || write_num !== 5'd0 || write_data !== 32'd0) begin
         n_err++; $display("FAIL rst_write: got en=%0b num=%0d data=%0h expected 0/0/0", write_en, write_num, write_data);
      end
      n_cmp++; if (md_ready !== 1'b1 || chk_pending !== 1'b0) begin
         n_err++; $display("FAIL rst_flags: got ready=%0b pend=%0b expected 1/0", md_ready, chk_pending);
      end
      rst = 1'b0;
      pipe_en = 1'b1; pipe_num = 5'd3; pipe_data = $urandom;
      md_valid = 1'b1; md_num = 5'd10; md_data = $urandom;
      cycle();
      md_num = 5'd11; md_data = $urandom;
      cycle();
      idle_inputs();
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL rst_prefill: got %0d expected 2", count); end
      #2 rst = 1'b1;
      model_reset();
      chk_num = 5'd10;
      #1;
      n_cmp++; if (count !== 3'd0 || write_en !== 1'b0 || md_ready !== 1'b1 || chk_pending !== 1'b0) begin
         n_err++; $display("FAIL rst_mid: got count=%0d en=%0b ready=%0b pend=%0b expected 0/0/1/0", count, write_en, md_ready, chk_pending);
      end
      #1 rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_cmp++; if (write_en !== 1'b0 || count !== 3'd0) begin
            n_err++; $display("FAIL rst_nodrain: got en=%0b count=%0d expected 0/0", write_en, count);
         end
      end
   endtask

   task automatic test_pass_through();
      pipe_en = 1'b1; pipe_num = 5'd5; pipe_data = 32'hDEADBEEF;
      cycle();
      n_cmp++; if (write_en !== 1'b1 || write_num !== 5'd5 || write_data !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL pass_write: got en=%0b num=%0d data=%0h expected 1/5/deadbeef", write_en, write_num, write_data);
      end
      idle_inputs();
      cycle();
      n_cmp++; if (write_en !== 1'b0 || write_num !== 5'd5 || write_data !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL pass_hold: got en=%0b num=%0d data=%0h expected 0/5/deadbeef", write_en, write_num, write_data);
      end
   endtask

   task automatic test_priority_drain();
      logic [31:0] d;
      md_valid = 1'b1; md_num = 5'd7; md_data = 32'h11;
      for (int k = 0; k < 3; k++) begin
         d = $urandom;
         pipe_en = 1'b1; pipe_num = 5'd3; pipe_data = d;
         cycle();
         md_valid = 1'b0;
         n_cmp++; if (write_en !== 1'b1 || write_num !== 5'd3 || write_data !== d || count !== 3'd1) begin
            n_err++; $display("FAIL prio_pipe%0d: got en=%0b num=%0d data=%0h count=%0d expected 1/3/%0h/1", k, write_en, write_num, write_data, count, d);
         end
      end
      idle_inputs();
      cycle();
      n_cmp++; if (write_en !== 1'b1 || write_num !== 5'd7 || write_data !== 32'h11 || count !== 3'd0) begin
         n_err++; $display("FAIL prio_drain: got en=%0b num=%0d data=%0h count=%0d expected 1/7/11/0", write_en, write_num, write_data, count);
      end
   endtask

   task automatic test_full();
      pipe_en = 1'b1; pipe_num = 5'd2;
      for (int k = 1; k <= 4; k++) begin
         pipe_data = $urandom;
         md_valid = 1'b1; md_num = 5'(k); md_data = 32'h100 + k;
         cycle();
         n_cmp++; if (md_ready !== (k < 4) || count !== 3'(k)) begin
            n_err++; $display("FAIL full_fill%0d: got ready=%0b count=%0d expected %0b/%0d", k, md_ready, count, k < 4, k);
         end
      end
      md_num = 5'd5; md_data = 32'h105;
      repeat (2) cycle();
      n_cmp++; if (md_ready !== 1'b0 || count !== 3'd4 || last_acc !== 1'b0) begin
         n_err++; $display("FAIL full_hold: got ready=%0b count=%0d expected 0/4", md_ready, count);
      end
      pipe_en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cycle();
         if (last_acc) md_valid = 1'b0;
         n_cmp++; if (write_en !== 1'b1 || write_num !== 5'(k) || write_data !== 32'h100 + k) begin
            n_err++; $display("FAIL full_drain%0d: got en=%0b num=%0d data=%0h expected 1/%0d/%0h", k, write_en, write_num, write_data, k, 32'h100 + k);
         end
         if (k == 1) begin
            n_cmp++; if (md_ready !== 1'b1 || count !== 3'd3) begin
               n_err++; $display("FAIL full_reopen: got ready=%0b count=%0d expected 1/3", md_ready, count);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_wrap();
      logic [4:0]  en_n [10];
      logic [31:0] en_d [10];
      int idx = 0;
      int retired = 0;
      int cyc = 0;
      for (int i = 0; i < 10; i++) begin
         en_n[i] = 5'($urandom_range(1, 31));
         en_d[i] = $urandom;
      end
      while (retired < 10 && cyc < 200) begin
         pipe_en = cyc[0]; pipe_num = 5'($urandom_range(1, 31)); pipe_data = $urandom;
         md_valid = (idx < 10);
         md_num   = (idx < 10) ? en_n[idx] : 5'd0;
         md_data  = (idx < 10) ? en_d[idx] : 32'd0;
         cycle();
         cyc++;
         if (last_acc && idx < 10) idx++;
         n_cmp++; if (write_en !== m_we || write_num !== m_wn || write_data !== m_wd || count !== CW'(mq.size())) begin
            n_err++; $display("FAIL wrap_model c%0d: got en=%0b num=%0d data=%0h count=%0d expected %0b/%0d/%0h/%0d",
                              cyc, write_en, write_num, write_data, count, m_we, m_wn, m_wd, mq.size());
         end
         n_cmp++; if (count > 3'd4) begin n_err++; $display("FAIL wrap_bound: got count=%0d expected <=4", count); end
         if (write_en === 1'b1 && !last_take) begin
            n_cmp++; if (write_num !== en_n[retired] || write_data !== en_d[retired]) begin
               n_err++; $display("FAIL wrap_order%0d: got %0d/%0h expected %0d/%0h", retired, write_num, write_data, en_n[retired], en_d[retired]);
            end
            retired++;
         end
      end
      n_cmp++; if (retired != 10) begin n_err++; $display("FAIL wrap_timeout: got %0d retired expected 10", retired); end
      idle_inputs();
   endtask

   task automatic test_hazard();
      pipe_en = 1'b1; pipe_num = 5'd4; pipe_data = $urandom;
      md_valid = 1'b1; md_num = 5'd9; md_data = $urandom;
      cycle();
      md_valid = 1'b0;
      chk_num = 5'd9; #1;
      n_cmp++; if (chk_pending !== 1'b1) begin n_err++; $display("FAIL haz_set: got %0b expected 1", chk_pending); end
      cycle();
      n_cmp++; if (chk_pending !== 1'b1) begin n_err++; $display("FAIL haz_stay: got %0b expected 1", chk_pending); end
      chk_num = 5'd0; #1;
      n_cmp++; if (chk_pending !== 1'b0) begin n_err++; $display("FAIL haz_r0: got %0b expected 0", chk_pending); end
      chk_num = 5'd9;
      pipe_en = 1'b0;
      cycle();
      n_cmp++; if (write_en !== 1'b1 || write_num !== 5'd9 || chk_pending !== 1'b0) begin
         n_err++; $display("FAIL haz_clear: got en=%0b num=%0d pend=%0b expected 1/9/0", write_en, write_num, chk_pending);
      end
      md_valid = 1'b1; md_num = 5'd0; md_data = $urandom;
      n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL md0_ready: got %0b expected 1", md_ready); end
      cycle();
      md_valid = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL md0_count: got %0d expected 0", count); end
      cycle();
      n_cmp++; if (write_en !== 1'b0) begin n_err++; $display("FAIL md0_write: got %0b expected 0", write_en); end
      pipe_en = 1'b1; pipe_num = 5'd6; pipe_data = $urandom;
      md_valid = 1'b1; md_num = 5'd12; md_data = 32'hC0FFEE;
      cycle();
      md_valid = 1'b0; pipe_num = 5'd0;
      cycle();
      n_cmp++; if (write_en !== 1'b1 || write_num !== 5'd12 || write_data !== 32'hC0FFEE || count !== 3'd0) begin
         n_err++; $display("FAIL pipe0_drain: got en=%0b num=%0d data=%0h count=%0d expected 1/12/c0ffee/0", write_en, write_num, write_data, count);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         pipe_en   = ($urandom_range(0, 9) < 6);
         pipe_num  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         pipe_data = $urandom;
         md_valid  = ($urandom_range(0, 1) == 1);
         md_num    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         md_data   = $urandom;
         cycle();
         n_cmp++; if (write_en !== m_we || write_num !== m_wn || write_data !== m_wd) begin
            n_err++; $display("FAIL rand_write c%0d: got %0b/%0d/%0h expected %0b/%0d/%0h", c, write_en, write_num, write_data, m_we, m_wn, m_wd);
         end
         n_cmp++; if (count !== CW'(mq.size()) || md_ready !== (mq.size() != DEPTH)) begin
            n_err++; $display("FAIL rand_occ c%0d: got count=%0d ready=%0b expected %0d/%0b", c, count, md_ready, mq.size(), mq.size() != DEPTH);
         end
         chk_num = (mq.size() != 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)][36:32] : 5'($urandom_range(0, 31));
         #1;
         n_cmp++; if (chk_pending !== m_pend(chk_num)) begin
            n_err++; $display("FAIL rand_pend c%0d: chk=%0d got %0b expected %0b", c, chk_num, chk_pending, m_pend(chk_num));
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_priority_drain();
      test_full();
      test_wrap();
      test_hazard();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
